// File: rtl/instr_bus_responder.sv
// Instruction-cache refill responder: one 16-byte line per four-phase bus handshake,
// assembled from four sequential 32-bit reads on a single-outstanding req/gnt/rvalid port.
module instr_bus_responder #(
  parameter int unsigned BUS_ADDRESS_WIDTH = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         bus_valid_i,
  input  logic [BUS_ADDRESS_WIDTH-5:0] bus_addr_i,
  output logic [127:0]                 bus_data_o,
  output logic                         bus_valid_o,
  output logic                         mem_req_o,
  output logic [BUS_ADDRESS_WIDTH-3:0] mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic [31:0]                  mem_rdata_i,
  input  logic                         mem_rvalid_i,
  output logic                         busy_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;

  state_e                       state_q;
  logic [1:0]                   beat_q;
  logic [BUS_ADDRESS_WIDTH-5:0] line_addr_q;
  logic [127:0]                 data_q;
  logic                         bus_valid_q;
  logic                         mem_req_q;
  logic                         busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      line_addr_q <= '0;
      data_q      <= '0;
      bus_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus_valid_i) begin
            line_addr_q <= bus_addr_i;
            beat_q      <= 2'd0;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          // Request and address are held until the memory grants.
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            data_q[{beat_q, 5'd0} +: 32] <= mem_rdata_i;
            if (beat_q == 2'd3) begin
              bus_valid_q <= 1'b1;
              state_q     <= StAck;
            end else begin
              beat_q    <= beat_q + 2'd1;
              mem_req_q <= 1'b1;
              state_q   <= StReq;
            end
          end
        end
        StAck: begin
          // Full four-phase return: leave only once the cache has dropped its request.
          if (!bus_valid_i) begin
            bus_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            beat_q      <= 2'd0;
            state_q     <= StIdle;
          end
        end
        default: begin
          bus_valid_q <= 1'b0;
          mem_req_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus_data_o  = data_q;
  assign bus_valid_o = bus_valid_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = {line_addr_q, beat_q};
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_instr_bus_responder.sv
// Self-checking bench for instr_bus_responder: behavioural memory with random gnt stalls and
// read latency, line expectations computed from the memory contents.
module tb_instr_bus_responder;

  localparam int unsigned AW = 20;
  localparam int unsigned LW = AW - 4;
  localparam int unsigned WW = AW - 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          bus_valid_i = 1'b0;
  logic [LW-1:0] bus_addr_i = '0;
  logic [127:0]  bus_data_o;
  logic          bus_valid_o;
  logic          mem_req_o;
  logic [WW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic [31:0]   mem_rdata_i;
  logic          mem_rvalid_i;
  logic          busy_o;

  instr_bus_responder #(.BUS_ADDRESS_WIDTH(AW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus_valid_i  (bus_valid_i),
    .bus_addr_i   (bus_addr_i),
    .bus_data_o   (bus_data_o),
    .bus_valid_o  (bus_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model knobs
  bit            pattern_mode = 1'b0;
  logic [31:0]   salt = '0;
  int            stall_max = 0;
  int            lat_min = 1;
  int            lat_max = 1;
  bit            spurious_on = 1'b0;
  logic [WW-1:0] fired_q[$];
  int            grants = 0;

  function automatic logic [31:0] mem_word(input logic [WW-1:0] a);
    if (pattern_mode) return 32'h1111_1111 * (32'(a[1:0]) + 32'd1);
    return (32'(a) * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [127:0] exp_line(input logic [LW-1:0] la);
    logic [127:0] l;
    for (int b = 0; b < 4; b++) l[32*b +: 32] = mem_word({la, 2'(b)});
    return l;
  endfunction

  // Memory: grants after a random stall, returns data after a random latency, one outstanding.
  initial begin : mem_model
    bit            fire = 1'b0;
    bit            rd_pending = 1'b0;
    bit            req_seen = 1'b0;
    bit            stall_chk = 1'b0;
    logic [WW-1:0] fire_addr = '0;
    logic [WW-1:0] rd_addr = '0;
    logic [WW-1:0] stall_addr = '0;
    int            rd_wait = 0;
    int            stall_cnt = 0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (!rst_ni) begin
        rd_pending = 1'b0;
        req_seen = 1'b0;
        fire = 1'b0;
      end
      if (fire) begin
        rd_addr = fire_addr;
        rd_wait = $urandom_range(lat_max, lat_min) - 1;
        rd_pending = 1'b1;
        req_seen = 1'b0;
      end
      if (rd_pending) begin
        if (rd_wait == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = mem_word(rd_addr);
          rd_pending = 1'b0;
        end else begin
          rd_wait--;
        end
      end else if (spurious_on && !mem_req_o) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = $urandom;
      end
      if (mem_req_o) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          stall_cnt = $urandom_range(stall_max, 0);
        end
        if (stall_cnt == 0) mem_gnt_i = 1'b1;
        else stall_cnt--;
      end
      @(negedge clk_i);
      if (stall_chk && rst_ni) begin
        n_tests++;
        if (!(mem_req_o === 1'b1 && mem_addr_o === stall_addr)) begin
          n_fail++;
          $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h",
                   mem_req_o, mem_addr_o, stall_addr);
        end
      end
      stall_chk = mem_req_o && !mem_gnt_i;
      stall_addr = mem_addr_o;
      fire = mem_req_o && mem_gnt_i;
      fire_addr = mem_addr_o;
      if (fire) begin
        fired_q.push_back(mem_addr_o);
        grants++;
      end
    end
  end

  task automatic start_req(input logic [LW-1:0] a);
    @(posedge clk_i);
    #1;
    bus_valid_i = 1'b1;
    bus_addr_i = a;
  endtask

  task automatic wait_ack(output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (bus_valid_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if ({bus_valid_o, mem_req_o, busy_o} !== 3'b000 || mem_addr_o !== '0 || bus_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset: valid=%b req=%b busy=%b addr=%h data=%h, required all zero",
               bus_valid_o, mem_req_o, busy_o, mem_addr_o, bus_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    pattern_mode = 1'b1;
    stall_max = 0;
    lat_min = 1;
    lat_max = 1;
    fired_q.delete();
    grants = 0;
    start_req(16'h0123);
    wait_ack(cyc, ok);
    n_tests++;
    if (!ok || cyc != 9) begin
      n_fail++;
      $display("FAIL basic_latency: ack=%b after %0d cycles, required ack after 9", ok, cyc);
    end
    n_tests++;
    if (fired_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_grants: %0d grants, required 4", fired_q.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        n_tests++;
        if (fired_q[b] !== WW'(18'h0048C + b)) begin
          n_fail++;
          $display("FAIL basic_addr%0d: %h, required %h", b, fired_q[b], 18'h0048C + b);
        end
      end
    end
    n_tests++;
    if (bus_data_o !== 128'h44444444_33333333_22222222_11111111) begin
      n_fail++;
      $display("FAIL basic_data: %h, required 44444444333333332222222211111111", bus_data_o);
    end
  endtask

  task automatic test_hold_ack();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      n_tests++;
      if (bus_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ack%0d: valid=%b req=%b, required valid=1 req=0",
                 i, bus_valid_o, mem_req_o);
      end
    end
    bus_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_tests++;
    if (bus_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_release: valid=%b busy=%b, required 0 0", bus_valid_o, busy_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      n_tests++;
      if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet%0d: req=%b busy=%b, required 0 0", i, mem_req_o, busy_o);
      end
    end
  endtask

  task automatic test_spurious();
    logic [127:0] held;
    logic [LW-1:0] la;
    int cyc;
    bit ok;
    held = bus_data_o;
    spurious_on = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    spurious_on = 1'b0;
    n_tests++;
    if (bus_data_o !== held || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_idle: data=%h busy=%b, required data=%h busy=0",
               bus_data_o, busy_o, held);
    end
    pattern_mode = 1'b0;
    salt = $urandom;
    la = LW'($urandom);
    start_req(la);
    wait_ack(cyc, ok);
    spurious_on = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    spurious_on = 1'b0;
    n_tests++;
    if (!ok || bus_valid_o !== 1'b1 || bus_data_o !== exp_line(la)) begin
      n_fail++;
      $display("FAIL spurious_ack: valid=%b data=%h, required valid=1 data=%h",
               bus_valid_o, bus_data_o, exp_line(la));
    end
    bus_valid_i = 1'b0;
    @(posedge clk_i);
  endtask

  task automatic test_random();
    logic [LW-1:0] la;
    int cyc;
    bit ok;
    pattern_mode = 1'b0;
    stall_max = 3;
    lat_min = 1;
    lat_max = 4;
    for (int n = 0; n < 16; n++) begin
      la = LW'($urandom);
      salt = $urandom;
      fired_q.delete();
      grants = 0;
      start_req(la);
      @(posedge clk_i);
      #1;
      bus_addr_i = LW'($urandom);  // must be ignored once accepted
      wait_ack(cyc, ok);
      n_tests++;
      if (!ok || grants != 4 || bus_data_o !== exp_line(la)) begin
        n_fail++;
        $display("FAIL random%0d: ack=%b grants=%0d data=%h, required ack=1 grants=4 data=%h",
                 n, ok, grants, bus_data_o, exp_line(la));
      end
      for (int b = 0; b < fired_q.size() && b < 4; b++) begin
        n_tests++;
        if (fired_q[b] !== {la, 2'(b)}) begin
          n_fail++;
          $display("FAIL random%0d_addr%0d: %h, required %h", n, b, fired_q[b], {la, 2'(b)});
        end
      end
      repeat ($urandom_range(3, 0)) @(posedge clk_i);
      #1;
      bus_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      n_tests++;
      if (busy_o !== 1'b0 || bus_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d_release: busy=%b valid=%b, required 0 0", n, busy_o, bus_valid_o);
      end
    end
  endtask

  task automatic test_early_drop();
    logic [LW-1:0] la;
    int cyc;
    int acks;
    bit ok;
    bit seen;
    stall_max = 1;
    lat_min = 1;
    lat_max = 2;
    salt = $urandom;
    la = LW'($urandom);
    fired_q.delete();
    grants = 0;
    start_req(la);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (fired_q.size() >= 2) seen = 1'b1;
    end
    bus_valid_i = 1'b0;
    wait_ack(cyc, ok);
    n_tests++;
    if (!seen || !ok || grants != 4 || bus_data_o !== exp_line(la)) begin
      n_fail++;
      $display("FAIL early_drop: ack=%b grants=%0d data=%h, required ack=1 grants=4 data=%h",
               ok, grants, bus_data_o, exp_line(la));
    end
    acks = 1;
    for (int i = 0; i < 10 && bus_valid_o; i++) begin
      @(posedge clk_i);
      #1;
      if (bus_valid_o) acks++;
    end
    n_tests++;
    if (acks != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL early_drop_ack: ack lasted %0d cycles busy=%b, required 1 cycle busy=0",
               acks, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] la;
    int cyc;
    bit ok;
    bit seen;
    stall_max = 0;
    lat_min = 4;
    lat_max = 4;
    salt = $urandom;
    fired_q.delete();
    start_req(LW'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (fired_q.size() >= 3) seen = 1'b1;
    end
    @(posedge clk_i);
    #2;
    n_tests++;
    if (!seen || busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait: reached=%b busy=%b req=%b, required 1 1 0", seen, busy_o, mem_req_o);
    end
    rst_ni = 1'b0;
    bus_valid_i = 1'b0;
    #1;
    n_tests++;
    if ({bus_valid_o, mem_req_o, busy_o} !== 3'b000 || bus_data_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b req=%b busy=%b data=%h, required all zero",
               bus_valid_o, mem_req_o, busy_o, bus_data_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    lat_min = 1;
    lat_max = 3;
    la = LW'($urandom);
    fired_q.delete();
    start_req(la);
    wait_ack(cyc, ok);
    n_tests++;
    if (!ok || fired_q.size() != 4 || bus_data_o !== exp_line(la)) begin
      n_fail++;
      $display("FAIL refetch: ack=%b grants=%0d data=%h, required ack=1 grants=4 data=%h",
               ok, fired_q.size(), bus_data_o, exp_line(la));
    end else begin
      n_tests++;
      if (fired_q[0] !== {la, 2'b00}) begin
        n_fail++;
        $display("FAIL refetch_beat0: %h, required %h", fired_q[0], {la, 2'b00});
      end
    end
    bus_valid_i = 1'b0;
    @(posedge clk_i);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold_ack();
    test_spurious();
    test_random();
    test_early_drop();
    test_reset_mid();
    repeat (3) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
